// File: rtl/nfc_pi_read_sequencer.sv
// NAND data-out read sequencer: buffer reset, DQS preamble, RE burst, delayed
// capture window and drain, plus serialised IDELAY tap loads between bursts.
//
// state   | meaning
// --------+--------------------------------------------------------------
// sIdle   | ready; accepts a burst request or a tap-load request
// sBrst   | capture FIFO held in reset
// sPre    | DQS preamble before the first RE toggle
// sXfer   | RE toggling, one word per cycle
// sCapt   | RE stopped; delayed capture window still open
// sDrain  | input pipeline flushing into the FIFO
// sDone   | one-cycle completion pulse (also reached on abort)
// sTapLd  | tap value presented with the load strobe
// sTWait  | waiting for IDELAYCTRL ready before acknowledging
module nfc_pi_read_sequencer #(
  parameter int BufResetCycles = 6,  // >= 1
  parameter int PreambleCycles = 2,  // >= 1
  parameter int CaptureLatency = 4,  // 0..15
  parameter int DrainCycles    = 6   // >= 1
) (
  input  logic        iSystemClock,
  input  logic        iModuleResetN,
  input  logic        iStart,
  input  logic [15:0] iByteCount,
  input  logic        iAbort,
  input  logic        iTapReq,
  input  logic [4:0]  iTapValue,
  input  logic        iPI_DelayReady,
  output logic        oReady,
  output logic        oBusy,
  output logic        oDone,
  output logic        oTapAck,
  output logic        oPI_BufferReset,
  output logic        oRE_Toggle,
  output logic        oPI_Buff_WE,
  output logic [3:0]  oAddressLatchEnable,
  output logic        oPI_DelayTapLoad,
  output logic [4:0]  oPI_DelayTap
);

  typedef enum logic [3:0] {
    sIdle, sBrst, sPre, sXfer, sCapt, sDrain, sDone, sTapLd, sTWait
  } state_t;

  localparam logic [15:0] BrstLoad  = 16'(BufResetCycles - 1);
  localparam logic [15:0] PreLoad   = 16'(PreambleCycles - 1);
  localparam logic [15:0] CaptLoad  = 16'((CaptureLatency > 0) ? CaptureLatency - 1 : 0);
  localparam logic [15:0] DrainLoad = 16'(DrainCycles - 1);

  state_t      curState, nxtState;
  logic [15:0] timer, timerNxt;
  logic [15:0] wordCnt, wordCntNxt;
  logic [15:0] wordsM1;
  logic        tapPending, tapPendingNxt;
  logic        tapAck;
  logic [4:0]  delayTap;
  logic        abortHit;
  logic        reToggle;
  logic        captureWin;

  // Words minus one: ceil(max(n,1)/2) - 1 == (n-1)>>1 for n >= 1, never overflows.
  assign wordsM1  = (iByteCount == 16'd0) ? 16'd0 : ((iByteCount - 16'd1) >> 1);
  assign abortHit = iAbort && (curState inside {sBrst, sPre, sXfer, sCapt, sDrain});

  always_comb begin
    nxtState      = curState;
    timerNxt      = timer;
    wordCntNxt    = wordCnt;
    tapPendingNxt = tapPending;
    case (curState)
      sIdle: begin
        if (iStart) begin
          nxtState   = sBrst;
          timerNxt   = BrstLoad;
          wordCntNxt = wordsM1;
          if (iTapReq) tapPendingNxt = 1'b1;
        end else if (iTapReq || tapPending) begin
          nxtState      = sTapLd;
          tapPendingNxt = 1'b0;
        end
      end
      sBrst: begin
        if (timer == 16'd0) begin
          nxtState = sPre;
          timerNxt = PreLoad;
        end else begin
          timerNxt = timer - 16'd1;
        end
      end
      sPre: begin
        if (timer == 16'd0) nxtState = sXfer;
        else timerNxt = timer - 16'd1;
      end
      sXfer: begin
        if (wordCnt == 16'd0) begin
          if (CaptureLatency == 0) begin
            nxtState = sDrain;
            timerNxt = DrainLoad;
          end else begin
            nxtState = sCapt;
            timerNxt = CaptLoad;
          end
        end else begin
          wordCntNxt = wordCnt - 16'd1;
        end
      end
      sCapt: begin
        if (timer == 16'd0) begin
          nxtState = sDrain;
          timerNxt = DrainLoad;
        end else begin
          timerNxt = timer - 16'd1;
        end
      end
      sDrain: begin
        if (timer == 16'd0) nxtState = sDone;
        else timerNxt = timer - 16'd1;
      end
      sDone:  nxtState = sIdle;
      sTapLd: nxtState = sTWait;
      sTWait: if (iPI_DelayReady) nxtState = sIdle;
      default: nxtState = sIdle;
    endcase
    if (abortHit) nxtState = sDone;
  end

  always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
    if (!iModuleResetN) begin
      curState   <= sIdle;
      timer      <= '0;
      wordCnt    <= '0;
      tapPending <= 1'b0;
      tapAck     <= 1'b0;
      delayTap   <= '0;
    end else begin
      curState   <= nxtState;
      timer      <= timerNxt;
      wordCnt    <= wordCntNxt;
      tapPending <= tapPendingNxt;
      tapAck     <= (curState == sTWait) && iPI_DelayReady;
      if (curState == sIdle && nxtState == sTapLd) delayTap <= iTapValue;
    end
  end

  assign reToggle = (curState == sXfer);

  generate
    if (CaptureLatency == 0) begin : gCapDirect
      assign captureWin = reToggle;
    end else begin : gCapPipe
      logic [CaptureLatency-1:0] capSr;
      always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
        if (!iModuleResetN) begin
          capSr <= '0;
        end else if (abortHit) begin
          capSr <= '0;
        end else begin
          capSr[0] <= reToggle;
          for (int i = 1; i < CaptureLatency; i++) capSr[i] <= capSr[i-1];
        end
      end
      assign captureWin = capSr[CaptureLatency-1];
    end
  endgenerate

  assign oReady              = (curState == sIdle);
  assign oBusy               = (curState != sIdle);
  assign oDone               = (curState == sDone);
  assign oTapAck             = tapAck;
  assign oPI_BufferReset     = (curState == sBrst);
  assign oRE_Toggle          = reToggle;
  assign oPI_Buff_WE         = captureWin;
  assign oAddressLatchEnable = {3'b000, captureWin};
  assign oPI_DelayTapLoad    = (curState == sTapLd);
  assign oPI_DelayTap        = delayTap;

endmodule

// File: tb/tb_nfc_pi_read_sequencer.sv
// Self-checking bench for nfc_pi_read_sequencer: directed and randomised bursts
// compared cycle by cycle against a timeline model built from the burst rules.
module tb_nfc_pi_read_sequencer;

  localparam int BR  = 6;
  localparam int PRE = 2;
  localparam int LAT = 4;
  localparam int DRN = 6;

  logic        iSystemClock = 1'b0;
  logic        iModuleResetN;
  logic        iStart;
  logic [15:0] iByteCount;
  logic        iAbort;
  logic        iTapReq;
  logic [4:0]  iTapValue;
  logic        iPI_DelayReady;
  logic        oReady, oBusy, oDone, oTapAck, oPI_BufferReset, oRE_Toggle, oPI_Buff_WE;
  logic [3:0]  oAddressLatchEnable;
  logic        oPI_DelayTapLoad;
  logic [4:0]  oPI_DelayTap;

  int checks = 0;
  int errors = 0;

  nfc_pi_read_sequencer #(
    .BufResetCycles(BR), .PreambleCycles(PRE), .CaptureLatency(LAT), .DrainCycles(DRN)
  ) dut (
    .iSystemClock(iSystemClock), .iModuleResetN(iModuleResetN), .iStart(iStart),
    .iByteCount(iByteCount), .iAbort(iAbort), .iTapReq(iTapReq), .iTapValue(iTapValue),
    .iPI_DelayReady(iPI_DelayReady), .oReady(oReady), .oBusy(oBusy), .oDone(oDone),
    .oTapAck(oTapAck), .oPI_BufferReset(oPI_BufferReset), .oRE_Toggle(oRE_Toggle),
    .oPI_Buff_WE(oPI_Buff_WE), .oAddressLatchEnable(oAddressLatchEnable),
    .oPI_DelayTapLoad(oPI_DelayTapLoad), .oPI_DelayTap(oPI_DelayTap)
  );

  always #5 iSystemClock = ~iSystemClock;

  // {ready, busy, done, bufReset, re, we, ale[3:0], tapLoad, tapAck}
  logic [11:0] obsVec;
  assign obsVec = {oReady, oBusy, oDone, oPI_BufferReset, oRE_Toggle, oPI_Buff_WE,
                   oAddressLatchEnable, oPI_DelayTapLoad, oTapAck};

  function automatic logic [11:0] mkVec(logic rd, logic bz, logic dn, logic br, logic re,
                                        logic we, logic tl, logic ta);
    return {rd, bz, dn, br, re, we, 3'b000, we, tl, ta};
  endfunction

  function automatic int wordsOf(int bytes);
    return ((bytes == 0 ? 1 : bytes) + 1) / 2;
  endfunction

  function automatic int normDone(int bytes);
    return 1 + BR + PRE + wordsOf(bytes) + LAT + DRN;
  endfunction

  // Index 0 is the IDLE cycle in which the request is presented.
  function automatic logic [11:0] expVec(int i, int w, int abortIdx);
    int reS, endI;
    reS  = 1 + BR + PRE;
    endI = (abortIdx > 0) ? abortIdx + 1 : reS + w + LAT + DRN;
    if (i == 0 || i > endI) return mkVec(1, 0, 0, 0, 0, 0, 0, 0);
    if (i == endI)          return mkVec(0, 1, 1, 0, 0, 0, 0, 0);
    return mkVec(0, 1, 0, i < 1 + BR, i >= reS && i < reS + w,
                 i >= reS + LAT && i < reS + LAT + w, 0, 0);
  endfunction

  task automatic chk(input string tag, input int idx, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s idx=%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic runSeq(input string tag, input int bytes, input int abortIdx,
                        input bit tapWith, input int stopIdx);
    int w, endI;
    w    = wordsOf(bytes);
    endI = (abortIdx > 0) ? abortIdx + 1 : normDone(bytes);
    iStart     = 1'b1;
    iByteCount = 16'(bytes);
    iTapReq    = tapWith;
    iAbort     = 1'($urandom_range(0, 1));
    for (int i = 0; i <= endI + 1; i++) begin
      @(negedge iSystemClock);
      chk(tag, i, obsVec, expVec(i, w, abortIdx));
      if (i == stopIdx) return;
      @(posedge iSystemClock);
      #1;
      iByteCount = 16'($urandom);
      iStart     = (i + 1 <= endI) ? 1'($urandom_range(0, 1)) : 1'b0;
      iTapReq    = (i + 1 <= endI) ? 1'($urandom_range(0, 1)) : 1'b0;
      iAbort     = (i + 1 == abortIdx) ? 1'b1 :
                   (i + 1 == endI) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic doTap(input string tag, input logic [4:0] v, input int waitN, input bit drive);
    if (drive) begin
      iTapReq   = 1'b1;
      iTapValue = v;
      @(negedge iSystemClock);
      chk({tag, "_idle"}, 0, obsVec, mkVec(1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge iSystemClock);
      #1;
      iTapReq = 1'b0;
    end
    @(negedge iSystemClock);
    chk({tag, "_load"}, 1, obsVec, mkVec(0, 1, 0, 0, 0, 0, 1, 0));
    chk({tag, "_value"}, 1, {7'b0, oPI_DelayTap}, {7'b0, v});
    @(posedge iSystemClock);
    #1;
    iTapValue = 5'($urandom);
    for (int k = 0; k < waitN; k++) begin
      iStart  = 1'($urandom_range(0, 1));
      iAbort  = 1'($urandom_range(0, 1));
      iTapReq = 1'($urandom_range(0, 1));
      @(negedge iSystemClock);
      chk({tag, "_wait"}, 2 + k, obsVec, mkVec(0, 1, 0, 0, 0, 0, 0, 0));
      chk({tag, "_hold"}, 2 + k, {7'b0, oPI_DelayTap}, {7'b0, v});
      @(posedge iSystemClock);
      #1;
    end
    iStart = 1'b0; iAbort = 1'b0; iTapReq = 1'b0;
    iPI_DelayReady = 1'b1;
    @(negedge iSystemClock);
    chk({tag, "_rdy"}, 2 + waitN, obsVec, mkVec(0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge iSystemClock);
    #1;
    iPI_DelayReady = 1'($urandom_range(0, 1));
    @(negedge iSystemClock);
    chk({tag, "_ack"}, 3 + waitN, obsVec, mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    @(posedge iSystemClock);
    #1;
    iPI_DelayReady = 1'b0;
    @(negedge iSystemClock);
    chk({tag, "_after"}, 4 + waitN, obsVec, mkVec(1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge iSystemClock);
    #1;
  endtask

  initial begin
    int b, ab;
    iModuleResetN = 1'b0; iStart = 1'b0; iByteCount = '0; iAbort = 1'b0;
    iTapReq = 1'b0; iTapValue = '0; iPI_DelayReady = 1'b0;
    repeat (2) @(negedge iSystemClock);
    chk("reset", 0, obsVec, mkVec(1, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_tap", 0, {7'b0, oPI_DelayTap}, 12'h000);
    iModuleResetN = 1'b1;
    @(posedge iSystemClock);
    #1;

    runSeq("b8", 8, -1, 0, -1);
    runSeq("b0", 0, -1, 0, -1);
    runSeq("b7", 7, -1, 0, -1);
    runSeq("bFFFF", 16'hFFFF, -1, 0, -1);
    runSeq("abort16", 16, 1 + BR + PRE + 2, 0, -1);

    iTapValue = 5'h13;
    runSeq("start_tap", 6, -1, 1, -1);
    doTap("tap_pend", 5'h13, 10, 0);

    for (int n = 0; n < 8; n++) begin
      b  = (n == 0) ? 1 : (n == 1) ? 2 : int'($urandom_range(0, 40));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, normDone(b) - 1)) : -1;
      runSeq("rand", b, ab, 0, -1);
      if ($urandom_range(0, 1) == 1)
        doTap("tap_rand", 5'($urandom_range(1, 31)), int'($urandom_range(0, 5)), 1);
    end

    // Reset while RE and the capture window are both active.
    runSeq("rst_mid", 16, -1, 0, 1 + BR + PRE + LAT + 1);
    #2;
    iModuleResetN = 1'b0;
    #1;
    chk("rst_async", 0, obsVec, mkVec(1, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_async_tap", 0, {7'b0, oPI_DelayTap}, 12'h000);
    iStart = 1'b0; iAbort = 1'b0; iTapReq = 1'b0; iPI_DelayReady = 1'b0;
    @(negedge iSystemClock);
    iModuleResetN = 1'b1;
    @(posedge iSystemClock);
    #1;
    runSeq("after_rst", 4, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
